// File: rtl/l1_dcache_if.sv
// D-cache port bundle: pipeline-side request/response plus the 128-bit line port to memory.
// The cache is the slave; the pipeline/memory side (or a bench) drives the master view.
interface l1_dcache_if;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic         indirect;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, indirect,
        output mem_resp, mem_rdata,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, indirect,
        input  mem_resp, mem_rdata,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped write-back/write-allocate L1 D-cache with 16-byte lines and two-phase indirect
// (pointer-chasing) accesses; hits respond combinationally, misses go through WRITEBACK/FILL.
module l1_dcache #(
    parameter int INDEX_BITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    l1_dcache_if.slave  bus
);
    localparam int NUM_SETS = 1 << INDEX_BITS;
    localparam int TAG_W    = 12 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;

    state_e                  state_q;
    logic                    phase_q;
    logic [15:0]             ptr_q;
    logic [NUM_SETS-1:0]     valid_q;
    logic [NUM_SETS-1:0]     dirty_q;
    logic [TAG_W-1:0]        tag_q  [NUM_SETS];
    logic [127:0]            line_q [NUM_SETS];
    logic                    pmem_read_q;
    logic                    pmem_write_q;
    logic [15:0]             pmem_addr_q;
    logic [127:0]            pmem_wdata_q;

    logic [15:0]             eff;
    logic [INDEX_BITS-1:0]   set_idx;
    logic [TAG_W-1:0]        eff_tag;
    logic [6:0]              bit_off;
    logic [127:0]            cur_line;
    logic [15:0]             cur_word;
    logic [127:0]            merged_line;
    logic                    req;
    logic                    hit;
    logic                    final_acc;
    logic                    resp;

    // Phase 1 of an indirect access addresses through the latched pointer, not the bus.
    assign eff       = phase_q ? ptr_q : bus.mem_address;
    assign set_idx   = eff[INDEX_BITS+3:4];
    assign eff_tag   = eff[15:INDEX_BITS+4];
    assign bit_off   = {eff[3:1], 4'b0000};
    assign cur_line  = line_q[set_idx];
    assign cur_word  = cur_line[bit_off +: 16];
    assign req       = bus.mem_read | bus.mem_write;
    assign hit       = valid_q[set_idx] && (tag_q[set_idx] == eff_tag);
    assign final_acc = !bus.indirect || phase_q;
    assign resp      = (state_q == IDLE) && req && hit && final_acc;

    always_comb begin
        merged_line = cur_line;
        if (bus.mem_byte_enable[0]) merged_line[bit_off +: 8]         = bus.mem_wdata[7:0];
        if (bus.mem_byte_enable[1]) merged_line[(bit_off + 7'd8) +: 8] = bus.mem_wdata[15:8];
    end

    assign bus.mem_resp     = resp;
    assign bus.mem_rdata    = resp ? cur_word : 16'h0;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_addr_q;
    assign bus.pmem_wdata   = pmem_wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            ptr_q        <= 16'h0;
            valid_q      <= '0;
            dirty_q      <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= 16'h0;
            pmem_wdata_q <= 128'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!req) begin
                        phase_q <= 1'b0;
                    end else if (hit) begin
                        if (final_acc) begin
                            phase_q <= 1'b0;
                            if (bus.mem_write) begin
                                line_q[set_idx]  <= merged_line;
                                dirty_q[set_idx] <= 1'b1;
                            end
                        end else begin
                            ptr_q   <= cur_word;
                            phase_q <= 1'b1;
                        end
                    end else if (valid_q[set_idx] && dirty_q[set_idx]) begin
                        state_q      <= WRITEBACK;
                        pmem_write_q <= 1'b1;
                        pmem_addr_q  <= {tag_q[set_idx], set_idx, 4'b0000};
                        pmem_wdata_q <= cur_line;
                    end else begin
                        state_q     <= FILL;
                        pmem_read_q <= 1'b1;
                        pmem_addr_q <= {eff[15:4], 4'b0000};
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        dirty_q[set_idx] <= 1'b0;
                        pmem_write_q     <= 1'b0;
                        pmem_wdata_q     <= 128'h0;
                        pmem_read_q      <= 1'b1;
                        pmem_addr_q      <= {eff[15:4], 4'b0000};
                        state_q          <= FILL;
                    end
                end
                FILL: begin
                    // Lookup is retried from IDLE so the access completes on the following cycle.
                    if (bus.pmem_resp) begin
                        line_q[set_idx]  <= bus.pmem_rdata;
                        tag_q[set_idx]   <= eff_tag;
                        valid_q[set_idx] <= 1'b1;
                        dirty_q[set_idx] <= 1'b0;
                        pmem_read_q      <= 1'b0;
                        pmem_addr_q      <= 16'h0;
                        state_q          <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_dcache.sv
// Directed + randomized bench for l1_dcache: word-level reference memory, scoreboard of expected
// read data, and a line-level memory responder with variable latency.
module tb_l1_dcache;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l1_dcache_if bus();

    l1_dcache #(.INDEX_BITS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          rd;
        logic [15:0] data;
    } sb_t;

    typedef struct {
        bit           w;
        logic [15:0]  a;
        logic [127:0] d;
    } pm_t;

    sb_t          sbq[$];
    pm_t          pmlog[$];
    logic [15:0]  refm [32768];
    logic [127:0] pmem [4096];
    int           ncmp = 0;
    int           nerr = 0;
    int           req_cnt = 0;
    int           resp_cnt = 0;
    int           dly_fixed = -1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sync_ref();
        for (int l = 0; l < 4096; l++)
            for (int w = 0; w < 8; w++)
                refm[l*8 + w] = pmem[l][w*16 +: 16];
    endtask

    // One complete pipeline access; expected data is derived from the reference memory before driving.
    task automatic access(input string tag, input bit wr, input bit ind, input logic [15:0] a,
                          input logic [1:0] be, input logic [15:0] wd,
                          output int lat, output logic [15:0] rd);
        logic [15:0] ea;
        sb_t e;
        ea = ind ? refm[a[15:1]] : a;
        e.rd = !wr;
        e.data = refm[ea[15:1]];
        if (wr) begin
            if (be[0]) refm[ea[15:1]][7:0]  = wd[7:0];
            if (be[1]) refm[ea[15:1]][15:8] = wd[15:8];
        end
        sbq.push_back(e);
        @(negedge clk);
        bus.mem_read = !wr;
        bus.mem_write = wr;
        bus.indirect = ind;
        bus.mem_address = a;
        bus.mem_byte_enable = be;
        bus.mem_wdata = wd;
        lat = 0;
        rd = 16'h0;
        #1;
        while (!bus.mem_resp && lat < 400) begin
            @(negedge clk);
            #1;
            lat++;
        end
        req_cnt++;
        e = sbq.pop_front();
        if (!bus.mem_resp) begin
            chk({tag, "_timeout"}, {127'h0, bus.mem_resp}, 128'h1);
        end else begin
            rd = bus.mem_rdata;
            if (e.rd) chk(tag, {112'h0, rd}, {112'h0, e.data});
        end
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.indirect = 1'b0;
    endtask

    // Memory responder: answers each pmem request after 0..5 cycles (or a forced delay).
    initial begin
        int  wcnt;
        bit  pend;
        pend = 1'b0;
        wcnt = 0;
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.pmem_resp = 1'b0;
            if (reset || !(bus.pmem_read || bus.pmem_write)) pend = 1'b0;
            else if (!pend) begin
                pend = 1'b1;
                wcnt = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(0, 5));
            end
            if (pend) begin
                if (wcnt == 0) begin
                    if (bus.pmem_write) pmem[bus.pmem_address[15:4]] = bus.pmem_wdata;
                    else bus.pmem_rdata = pmem[bus.pmem_address[15:4]];
                    pmlog.push_back('{bus.pmem_write, bus.pmem_address, bus.pmem_wdata});
                    bus.pmem_resp = 1'b1;
                    pend = 1'b0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Response pulse counter, sampled just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (bus.mem_resp) resp_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          r0;
        logic [15:0] rd;
        logic [15:0] a;
        bit          wr;
        bit          ind;

        for (int i = 0; i < 32768; i++) refm[i] = 16'((i * 15445) ^ 42405);
        refm[16'h0010 >> 1] = 16'hBEEF;
        refm[16'h0012 >> 1] = 16'h1234;
        refm[16'h0020 >> 1] = 16'h0040;
        refm[16'h0040 >> 1] = 16'h5A5A;
        for (int l = 0; l < 4096; l++)
            for (int w = 0; w < 8; w++)
                pmem[l][w*16 +: 16] = refm[l*8 + w];

        reset = 1'b1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.indirect = 1'b0;
        bus.mem_address = 16'h0;
        bus.mem_byte_enable = 2'b00;
        bus.mem_wdata = 16'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_resp", {127'h0, bus.mem_resp}, 128'h0);
        chk("rst_rdata", {112'h0, bus.mem_rdata}, 128'h0);
        chk("rst_pmem_read", {127'h0, bus.pmem_read}, 128'h0);
        chk("rst_pmem_write", {127'h0, bus.pmem_write}, 128'h0);
        chk("rst_pmem_addr", {112'h0, bus.pmem_address}, 128'h0);
        chk("rst_pmem_wdata", bus.pmem_wdata, 128'h0);

        // Cold read miss, then hit (including odd byte address).
        pmlog.delete();
        access("t1_read", 0, 0, 16'h0010, 2'b11, 16'h0, lat, rd);
        chk("t1_rdata_const", {112'h0, rd}, {112'h0, 16'hBEEF});
        chk("t1_nfill", 128'(pmlog.size()), 128'd1);
        if (pmlog.size() > 0) begin
            chk("t1_fill_is_read", {127'h0, pmlog[0].w}, 128'h0);
            chk("t1_fill_addr", {112'h0, pmlog[0].a}, {112'h0, 16'h0010});
        end
        access("t1_hit", 0, 0, 16'h0011, 2'b11, 16'h0, lat, rd);
        chk("t1_hit_lat", 128'(lat), 128'd0);

        // Single-lane write, then read merged word.
        access("t2_write", 1, 0, 16'h0013, 2'b10, 16'hAB00, lat, rd);
        chk("t2_write_lat", 128'(lat), 128'd0);
        access("t2_read", 0, 0, 16'h0012, 2'b11, 16'h0, lat, rd);
        chk("t2_rdata_const", {112'h0, rd}, {112'h0, 16'hAB34});

        // Conflict miss on a dirty line: writeback then fill.
        pmlog.delete();
        access("t3_read", 0, 0, 16'h0090, 2'b11, 16'h0, lat, rd);
        chk("t3_ntrans", 128'(pmlog.size()), 128'd2);
        if (pmlog.size() == 2) begin
            chk("t3_wb_is_write", {127'h0, pmlog[0].w}, 128'h1);
            chk("t3_wb_addr", {112'h0, pmlog[0].a}, {112'h0, 16'h0010});
            chk("t3_wb_word1", {112'h0, pmlog[0].d[31:16]}, {112'h0, 16'hAB34});
            chk("t3_fill_addr", {112'h0, pmlog[1].a}, {112'h0, 16'h0090});
        end

        // Indirect read and write.
        r0 = resp_cnt;
        access("t4_ldi", 0, 1, 16'h0020, 2'b11, 16'h0, lat, rd);
        chk("t4_ldi_const", {112'h0, rd}, {112'h0, 16'h5A5A});
        @(negedge clk);
        chk("t4_single_resp", 128'(resp_cnt - r0), 128'd1);
        access("t4_sti", 1, 1, 16'h0020, 2'b11, 16'h1111, lat, rd);
        access("t4_tgt", 0, 0, 16'h0040, 2'b11, 16'h0, lat, rd);
        chk("t4_tgt_const", {112'h0, rd}, {112'h0, 16'h1111});
        access("t4_ptr", 0, 0, 16'h0020, 2'b11, 16'h0, lat, rd);
        chk("t4_ptr_const", {112'h0, rd}, {112'h0, 16'h0040});

        // Zero byte-enable write: data unchanged but line becomes dirty.
        access("t4_be0", 1, 0, 16'h0022, 2'b00, 16'hFFFF, lat, rd);
        access("t4_be0_rd", 0, 0, 16'h0022, 2'b11, 16'h0, lat, rd);
        pmlog.delete();
        access("t4_evict", 0, 0, 16'h00A0, 2'b11, 16'h0, lat, rd);
        chk("t4_be0_wb", 128'(pmlog.size()), 128'd2);
        if (pmlog.size() > 0) chk("t4_be0_wb_addr", {112'h0, pmlog[0].a}, {112'h0, 16'h0020});

        // Reset in the middle of a fill.
        access("t5_pre", 0, 0, 16'h0210, 2'b11, 16'h0, lat, rd);
        dly_fixed = 50;
        @(negedge clk);
        bus.mem_read = 1'b1;
        bus.mem_address = 16'h0200;
        repeat (2) @(negedge clk);
        chk("t5_pmem_read_hi", {127'h0, bus.pmem_read}, 128'h1);
        chk("t5_pmem_addr", {112'h0, bus.pmem_address}, {112'h0, 16'h0200});
        reset = 1'b1;
        bus.mem_read = 1'b0;
        @(negedge clk);
        chk("t5_pmem_read_lo", {127'h0, bus.pmem_read}, 128'h0);
        reset = 1'b0;
        dly_fixed = -1;
        sync_ref();
        pmlog.delete();
        access("t5_read", 0, 0, 16'h0200, 2'b11, 16'h0, lat, rd);
        chk("t5_miss", 128'(pmlog.size()), 128'd1);
        access("t5_read2", 0, 0, 16'h0210, 2'b11, 16'h0, lat, rd);
        chk("t5_inval", 128'(pmlog.size()), 128'd2);

        // Randomized back-to-back mix against the reference memory.
        for (int n = 0; n < 150; n++) begin
            a = {7'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            r0 = int'($urandom_range(0, 5));
            wr = (r0 == 3 || r0 == 4) || (r0 == 5 && $urandom_range(0, 1) == 1);
            ind = (r0 == 5);
            access("t6_rand", wr, ind, a, 2'($urandom_range(0, 3)), 16'($urandom), lat, rd);
        end
        @(negedge clk);
        chk("t6_resp_count", 128'(resp_cnt), 128'(req_cnt));
        chk("sb_empty", 128'(sbq.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
